// File: rtl/pdm_pkg.sv
// ---------------------------------------------------------------------------
// pdm_pkg
// Shared definitions for the PDM microphone capture block.
//   pdm_state_t : capture FSM states (IDLE, SETTLE, RUN)
//   pcm_width() : width of a per-window ones-count for a given window length.
//                 A window of N bits can hold N ones, so the count needs
//                 clog2(N)+1 bits.
// ---------------------------------------------------------------------------
package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } pdm_state_t;

    function automatic int pcm_width(input int dec_len);
        return $clog2(dec_len) + 1;
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// ---------------------------------------------------------------------------
// pdm_clk_gen
// Divides the system clock down to the microphone bit clock and produces the
// single-cycle strobes at which the capture logic samples sdata.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   run      in   divider runs while high, otherwise held at zero
//   sclk     out  mic bit clock: low for the first half of each period
//   l_stb    out  last low-phase cycle of a period (left channel sample point)
//   r_stb    out  last high-phase cycle of a period (right channel sample
//                 point), only when STEREO != 0
//   per_end  out  last cycle of an sclk period
// ---------------------------------------------------------------------------
module pdm_clk_gen #(
    parameter int CLK_DIV = 32,
    parameter int STEREO  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sclk,
    output logic l_stb,
    output logic r_stb,
    output logic per_end
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int HALF  = CLK_DIV / 2;
    localparam logic [DIV_W-1:0] L_POINT  = DIV_W'(HALF - 1);
    localparam logic [DIV_W-1:0] LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HIGH_BEG = DIV_W'(HALF);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    // Next divider value: wraps at the end of a period and collapses to zero
    // whenever the divider is stopped.
    always_comb begin
        div_next = '0;
        if (run && (div_cnt != LAST)) begin
            div_next = div_cnt + DIV_W'(1);
        end
    end

    // sclk is registered from div_next so the pin is glitch-free and always
    // equals (div_cnt >= CLK_DIV/2) for the registered div_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else begin
            div_cnt <= div_next;
            sclk    <= (div_next >= HIGH_BEG);
        end
    end

    assign per_end = run && (div_cnt == LAST);
    assign l_stb   = run && (div_cnt == L_POINT);
    assign r_stb   = (STEREO != 0) && per_end;

endmodule

// File: rtl/pdm_mic_capture.sv
// ---------------------------------------------------------------------------
// pdm_mic_capture
// Clocks one or two PDM microphones sharing a data line and turns each
// window of DEC_LEN bit-clock periods into an unsigned ones-count per channel.
// After enable, SETTLE_WIN windows are thrown away while the mics wake up.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   enable              capture enable; low returns to IDLE immediately
//   sdata               PDM data from the mic(s)
//   sclk, lrsel         mic bit clock and L/R select (tied low)
//   pcm_l, pcm_r        ones-count per window (pcm_r is 0 when mono)
//   pcm_valid/pcm_ready valid/ready handshake for pcm_l/pcm_r
//   overrun             sticky: a result replaced one that was never taken
//   overrun_clr         clears overrun (a coincident new overrun wins)
//   anout               last left-channel bit, for direct PWM monitoring
//   ampSD               amplifier enable, follows enable
// ---------------------------------------------------------------------------
module pdm_mic_capture
    import pdm_pkg::*;
#(
    parameter int CLK_DIV    = 32,
    parameter int DEC_LEN    = 64,
    parameter int STEREO     = 1,
    parameter int SETTLE_WIN = 2,
    localparam int PCM_W     = pcm_width(DEC_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sdata,
    output logic             sclk,
    output logic             lrsel,
    output logic [PCM_W-1:0] pcm_l,
    output logic [PCM_W-1:0] pcm_r,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             anout,
    output logic             ampSD
);

    localparam int BIT_W = $clog2(DEC_LEN);
    // settle_cnt only ever holds 0..SETTLE_WIN-1
    localparam int SET_W = (SETTLE_WIN < 2) ? 1 : $clog2(SETTLE_WIN);

    pdm_state_t       state;
    logic [SET_W-1:0] settle_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [PCM_W-1:0] acc_l;
    logic [PCM_W-1:0] acc_r;
    logic [PCM_W-1:0] res_l;
    logic [PCM_W-1:0] res_r;
    logic             run;
    logic             l_stb;
    logic             r_stb;
    logic             per_end;
    logic             window_end;
    logic             load;

    // Sampling stops in the very cycle enable drops, so a partial window is
    // never counted even though the FSM only reaches IDLE on the next edge.
    assign run = (state != IDLE) && enable;

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .STEREO  (STEREO)
    ) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .sclk    (sclk),
        .l_stb   (l_stb),
        .r_stb   (r_stb),
        .per_end (per_end)
    );

    assign window_end = per_end && (bit_cnt == BIT_W'(DEC_LEN - 1));

    // The R sample point coincides with the window end, so the right result
    // must include the bit being sampled right now. The L sample point never
    // lands on a period end, so acc_l is already complete.
    assign res_l = acc_l;
    assign res_r = (STEREO != 0) ? (acc_r + PCM_W'(sdata)) : '0;

    assign load  = window_end && (state == RUN);
    assign lrsel = 1'b0;
    assign ampSD = enable;

    // Capture FSM: SETTLE counts discarded windows before results go out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else if (!enable) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    settle_cnt <= '0;
                    state      <= (SETTLE_WIN == 0) ? RUN : SETTLE;
                end
                SETTLE: begin
                    if (window_end) begin
                        if (int'(settle_cnt) == SETTLE_WIN - 1) begin
                            state <= RUN;
                        end else begin
                            settle_cnt <= settle_cnt + SET_W'(1);
                        end
                    end
                end
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    // Bit-period counter and per-channel ones accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            acc_l   <= '0;
            acc_r   <= '0;
            anout   <= 1'b0;
        end else if (!run) begin
            bit_cnt <= '0;
            acc_l   <= '0;
            acc_r   <= '0;
        end else begin
            if (l_stb) begin
                acc_l <= acc_l + PCM_W'(sdata);
                anout <= sdata;
            end
            if (per_end) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (window_end) begin
                acc_l <= '0;
                acc_r <= '0;
            end else if (r_stb) begin
                acc_r <= acc_r + PCM_W'(sdata);
            end
        end
    end

    // Output register and handshake. A load always leaves valid high; it is
    // an overrun only when the previous result was still waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_l     <= '0;
            pcm_r     <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                pcm_l     <= res_l;
                pcm_r     <= res_r;
                pcm_valid <= 1'b1;
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end
            if (load && pcm_valid && !pcm_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pdm_mic_capture.md
PDM_MIC_CAPTURE -- requirements
Module: pdm_mic_capture

Interface
REQ-001 SHALL have parameter CLK_DIV, default 32: clk cycles per sclk period; even, >=4.
REQ-002 SHALL have parameter DEC_LEN, default 64: sclk periods per PCM window; power of 2, >=4.
REQ-003 SHALL have parameter STEREO, default 1: 1 = L and R channels, 0 = L only.
REQ-004 SHALL have parameter SETTLE_WIN, default 2: windows discarded after enable.
REQ-005 SHALL derive PCM_W = clog2(DEC_LEN)+1.
REQ-006 SHALL have port clk  in  1  system clock; rst_n  in  1  reset.
REQ-007 SHALL have port enable  in  1  capture enable.
REQ-008 SHALL have port sdata  in  1  PDM data from the mic(s).
REQ-009 SHALL have port sclk  out  1  mic bit clock; lrsel  out  1  mic L/R select, constant 0.
REQ-010 SHALL have port pcm_l, pcm_r  out  PCM_W each  unsigned ones-count per window.
REQ-011 SHALL have port pcm_valid  out  1; pcm_ready  in  1; valid/ready handshake.
REQ-012 SHALL have port overrun  out  1  sticky loss flag; overrun_clr  in  1  clears overrun.
REQ-013 SHALL have port anout  out  1  last L bit, for direct PWM monitoring; ampSD  out  1  amp enable.
REQ-014 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-015 SHALL run divider div_cnt 0..CLK_DIV-1 while enable=1; sclk = 1 when div_cnt >= CLK_DIV/2, else 0.
REQ-016 SHALL sample L at div_cnt = CLK_DIV/2-1 (last low-phase cycle) and, if STEREO=1, R at div_cnt = CLK_DIV-1 (last high-phase cycle).
REQ-017 SHALL register anout from each L sample; ampSD = enable.
REQ-018 SHALL keep FSM states IDLE, SETTLE, RUN; IDLE->SETTLE on enable=1; SETTLE->RUN after SETTLE_WIN windows; any state->IDLE on enable=0.
REQ-019 In IDLE: sclk=0, div_cnt=0, bit counter=0, accumulators=0, no samples taken.
REQ-020 SHALL count sclk periods modulo DEC_LEN, incrementing at div_cnt = CLK_DIV-1; window ends when count = DEC_LEN-1 at that cycle.
REQ-021 At window end, result = accumulator + sample taken in that cycle; accumulators reload to 0 in the same cycle.
REQ-022 Result range 0..DEC_LEN; no saturation or wrap permitted.
REQ-023 In RUN, window-end SHALL load pcm_l/pcm_r and set pcm_valid on the following cycle (1-cycle latency); in SETTLE results are discarded.
REQ-024 pcm_r SHALL be 0 when STEREO=0.
REQ-025 pcm_valid SHALL clear on cycle after pcm_valid & pcm_ready; data held stable while valid & !ready.
REQ-026 If a new result loads while pcm_valid=1 and pcm_ready=0: data overwritten, pcm_valid stays 1, overrun set.
REQ-027 If load coincides with pcm_ready=1: handshake completes, new data loads, pcm_valid stays 1, no overrun.
REQ-028 overrun_clr SHALL clear overrun; a simultaneous overrun event takes priority (overrun stays 1).
REQ-029 enable=0 mid-window SHALL discard the partial window; pending pcm_valid/data retained until handshaked.

Reset
REQ-030 On rst_n=0 SHALL immediately force state=IDLE, sclk=0, lrsel=0, pcm_l=pcm_r=0, pcm_valid=0, overrun=0, anout=0, all counters/accumulators 0.
REQ-031 After rst_n release SHALL begin with SETTLE on the first cycle enable=1 is seen.

Structure
REQ-032 SHALL place state enum and PCM width function in shared package pdm_pkg.
REQ-033 SHALL implement divider, sclk and L/R/period-end strobes in sub-module pdm_clk_gen.

Verification (CLK_DIV=32, DEC_LEN=64, STEREO=1, SETTLE_WIN=2 unless stated)
REQ-034 sdata=1 constant, ready=1 -> first pcm_valid 3*2048+1 clk after enable; pcm_l=pcm_r=64; then every 2048 cycles.
REQ-035 sdata=1 at L strobes, 0 at R strobes -> pcm_l=64, pcm_r=0; anout=1.
REQ-036 pcm_ready=0 across two RUN windows -> overrun=1, data = second window; overrun_clr pulse -> overrun=0.
REQ-037 enable dropped at sclk period 30 of a RUN window -> sclk=0 next cycle, no new pcm_valid; re-enable -> 2 settle windows again.
REQ-038 rst_n asserted mid-window asynchronously -> all REQ-030 values before next clk edge.
REQ-039 STEREO=0, sdata=1 -> pcm_l=64, pcm_r=0.
